// File: rtl/dds_sin_gen.sv
// Direct digital synthesiser: 24-bit phase accumulator with carry-synchronised
// frequency updates, quarter-wave sine lookup and a three-stage output pipeline.
module dds_sin_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        phase_clr,
  input  logic [23:0] freq_word,
  input  logic        freq_load,
  input  logic [7:0]  phase_off,
  output logic [15:0] sin_out,
  output logic        sin_valid,
  output logic        wrap,
  output logic        load_pending
);

  logic [23:0] acc;
  logic [23:0] active_word;
  logic [23:0] pending_word;
  logic [24:0] sum;
  logic        carry_edge;

  logic [7:0]  phase_idx;
  logic [1:0]  quad1;
  logic [5:0]  idx1;
  logic [6:0]  lut_addr;
  logic [14:0] lut_mag;
  logic [14:0] mag2;
  logic        neg2;
  logic [2:0]  valid_sr;

  assign sum        = {1'b0, acc} + {1'b0, active_word};
  assign carry_edge = enable & ~phase_clr & sum[24];
  assign phase_idx  = acc[23:16] + phase_off;
  assign sin_valid  = valid_sr[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      active_word  <= '0;
      pending_word <= '0;
      load_pending <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      if (phase_clr)
        acc <= '0;
      else if (enable)
        acc <= sum[23:0];
      wrap <= carry_edge;
      // A new word only lands on a carry edge (or when idle) so the phase never jumps mid-period;
      // the add on that edge already used the old word.
      if (freq_load && (!enable || carry_edge)) begin
        active_word  <= freq_word;
        load_pending <= 1'b0;
      end else if (freq_load) begin
        pending_word <= freq_word;
        load_pending <= 1'b1;
      end else if (load_pending && (carry_edge || !enable)) begin
        active_word  <= pending_word;
        load_pending <= 1'b0;
      end
    end
  end

  // Quarter-wave mirror: quadrants 1 and 3 read the table backwards.
  assign lut_addr = quad1[0] ? (7'd64 - {1'b0, idx1}) : {1'b0, idx1};

  always_comb begin
    lut_mag = '0;
    case (lut_addr)
      7'd0:  lut_mag = 15'd0;     7'd1:  lut_mag = 15'd804;   7'd2:  lut_mag = 15'd1608;  7'd3:  lut_mag = 15'd2410;
      7'd4:  lut_mag = 15'd3212;  7'd5:  lut_mag = 15'd4011;  7'd6:  lut_mag = 15'd4808;  7'd7:  lut_mag = 15'd5602;
      7'd8:  lut_mag = 15'd6393;  7'd9:  lut_mag = 15'd7179;  7'd10: lut_mag = 15'd7962;  7'd11: lut_mag = 15'd8739;
      7'd12: lut_mag = 15'd9512;  7'd13: lut_mag = 15'd10278; 7'd14: lut_mag = 15'd11039; 7'd15: lut_mag = 15'd11793;
      7'd16: lut_mag = 15'd12539; 7'd17: lut_mag = 15'd13279; 7'd18: lut_mag = 15'd14010; 7'd19: lut_mag = 15'd14732;
      7'd20: lut_mag = 15'd15446; 7'd21: lut_mag = 15'd16151; 7'd22: lut_mag = 15'd16846; 7'd23: lut_mag = 15'd17530;
      7'd24: lut_mag = 15'd18204; 7'd25: lut_mag = 15'd18868; 7'd26: lut_mag = 15'd19519; 7'd27: lut_mag = 15'd20159;
      7'd28: lut_mag = 15'd20787; 7'd29: lut_mag = 15'd21403; 7'd30: lut_mag = 15'd22005; 7'd31: lut_mag = 15'd22594;
      7'd32: lut_mag = 15'd23170; 7'd33: lut_mag = 15'd23731; 7'd34: lut_mag = 15'd24279; 7'd35: lut_mag = 15'd24811;
      7'd36: lut_mag = 15'd25329; 7'd37: lut_mag = 15'd25832; 7'd38: lut_mag = 15'd26319; 7'd39: lut_mag = 15'd26790;
      7'd40: lut_mag = 15'd27245; 7'd41: lut_mag = 15'd27683; 7'd42: lut_mag = 15'd28105; 7'd43: lut_mag = 15'd28510;
      7'd44: lut_mag = 15'd28898; 7'd45: lut_mag = 15'd29268; 7'd46: lut_mag = 15'd29621; 7'd47: lut_mag = 15'd29956;
      7'd48: lut_mag = 15'd30273; 7'd49: lut_mag = 15'd30571; 7'd50: lut_mag = 15'd30852; 7'd51: lut_mag = 15'd31113;
      7'd52: lut_mag = 15'd31356; 7'd53: lut_mag = 15'd31580; 7'd54: lut_mag = 15'd31785; 7'd55: lut_mag = 15'd31971;
      7'd56: lut_mag = 15'd32137; 7'd57: lut_mag = 15'd32285; 7'd58: lut_mag = 15'd32412; 7'd59: lut_mag = 15'd32521;
      7'd60: lut_mag = 15'd32609; 7'd61: lut_mag = 15'd32678; 7'd62: lut_mag = 15'd32728; 7'd63: lut_mag = 15'd32757;
      7'd64: lut_mag = 15'd32767;
      default: lut_mag = '0;
    endcase
  end

  // Data stages move only on enabled edges; the valid tag shifts every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quad1    <= '0;
      idx1     <= '0;
      mag2     <= '0;
      neg2     <= 1'b0;
      sin_out  <= '0;
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[1:0], enable};
      if (enable) begin
        quad1   <= phase_idx[7:6];
        idx1    <= phase_idx[5:0];
        mag2    <= lut_mag;
        neg2    <= quad1[1];
        sin_out <= neg2 ? (16'd0 - {1'b0, mag2}) : {1'b0, mag2};
      end
    end
  end

endmodule

// File: tb/tb_dds_sin_gen.sv
// Self-checking bench for dds_sin_gen: directed scenarios plus randomized
// traffic against a floating-point sine reference model.
module tb_dds_sin_gen;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        phase_clr;
  logic [23:0] freq_word;
  logic        freq_load;
  logic [7:0]  phase_off;
  logic [15:0] sin_out;
  logic        sin_valid;
  logic        wrap;
  logic        load_pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint      m_acc, m_word, m_pend;
  bit          m_lp, m_wrap;
  bit          en_h [3];
  int          ph_q [$];

  dds_sin_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .phase_clr(phase_clr),
    .freq_word(freq_word), .freq_load(freq_load), .phase_off(phase_off),
    .sin_out(sin_out), .sin_valid(sin_valid), .wrap(wrap), .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_sample(input int p);
    real s;
    int  r;
    s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 256.0);
    if (s >= 0.0) r = $rtoi(s + 0.5);
    else          r = -$rtoi(-s + 0.5);
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_word = 0; m_pend = 0; m_lp = 0; m_wrap = 0;
    en_h[0] = 0; en_h[1] = 0; en_h[2] = 0;
    ph_q.delete();
  endtask

  function automatic bit model_carry_next();
    return (m_acc + m_word) >= 64'd16777216;
  endfunction

  task automatic model_edge(input bit e, input bit pc, input bit fl, input logic [23:0] fw,
                            input logic [7:0] po);
    longint total;
    bit     carry;
    if (e) begin
      ph_q.push_back(int'(((m_acc >> 16) + longint'(po)) % 256));
      if (ph_q.size() > 3) void'(ph_q.pop_front());
    end
    en_h[2] = en_h[1]; en_h[1] = en_h[0]; en_h[0] = e;
    total = m_acc + m_word;
    carry = e && !pc && (total >= 64'd16777216);
    if (fl && (!e || carry)) begin
      m_word = longint'(fw); m_lp = 0;
    end else if (fl) begin
      m_pend = longint'(fw); m_lp = 1;
    end else if (m_lp && (carry || !e)) begin
      m_word = m_pend; m_lp = 0;
    end
    if (pc)     m_acc = 0;
    else if (e) m_acc = total % 64'd16777216;
    m_wrap = carry;
  endtask

  task automatic compare_all();
    logic [15:0] exp_s;
    exp_s = (ph_q.size() == 3) ? ref_sample(ph_q[0]) : 16'h0000;
    chk("sin_out", {16'h0, sin_out}, {16'h0, exp_s});
    chk("sin_valid", {31'h0, sin_valid}, {31'h0, en_h[2]});
    chk("wrap", {31'h0, wrap}, {31'h0, m_wrap});
    chk("load_pending", {31'h0, load_pending}, {31'h0, m_lp});
  endtask

  task automatic step(input bit fl, input logic [23:0] fw, input bit pc);
    bit          e;
    logic [7:0]  po;
    freq_load = fl; freq_word = fw; phase_clr = pc;
    e = enable; po = phase_off;
    @(posedge clk);
    model_edge(e, pc, fl, fw, po);
    #1;
    compare_all();
    freq_load = 1'b0; phase_clr = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_sin_out", {16'h0, sin_out}, 32'h0);
    chk("rst_sin_valid", {31'h0, sin_valid}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    chk("rst_load_pending", {31'h0, load_pending}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int  wraps;
    bit  found;
    reset = 1'b0; enable = 1'b0; phase_clr = 1'b0; freq_load = 1'b0;
    freq_word = '0; phase_off = '0;
    model_clear();
    #12;
    reset = 1'b1;

    // quarter-rate tone
    do_reset();
    enable = 1'b0; phase_off = 8'h00;
    step(1'b1, 24'h400000, 1'b0);
    chk("lp_idle_load", {31'h0, load_pending}, 32'h0);
    enable = 1'b1;
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, '0, 1'b0);
      if (wrap) wraps++;
      if (k == 1) chk("q_valid_k1", {31'h0, sin_valid}, 32'h0);
      if (k == 2) chk("q_valid_k2", {31'h0, sin_valid}, 32'h1);
      if (k == 2) chk("q_s0", {16'h0, sin_out}, 32'h0000);
      if (k == 3) chk("q_s1", {16'h0, sin_out}, 32'h7FFF);
      if (k == 4) chk("q_s2", {16'h0, sin_out}, 32'h0000);
      if (k == 5) chk("q_s3", {16'h0, sin_out}, 32'h8001);
    end
    chk("q_wrap_count", wraps, 4);

    // quarter-rate tone with 90 degree offset
    do_reset();
    enable = 1'b0; phase_off = 8'h40;
    step(1'b1, 24'h400000, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b0);
      if (k == 2) chk("off_s0", {16'h0, sin_out}, 32'h7FFF);
      if (k == 3) chk("off_s1", {16'h0, sin_out}, 32'h0000);
      if (k == 4) chk("off_s2", {16'h0, sin_out}, 32'h8001);
      if (k == 5) chk("off_s3", {16'h0, sin_out}, 32'h0000);
    end

    // full 256-sample period
    do_reset();
    enable = 1'b0; phase_off = 8'h00;
    step(1'b1, 24'h010000, 1'b0);
    enable = 1'b1;
    wraps = 0;
    for (int k = 0; k < 260; k++) begin
      step(1'b0, '0, 1'b0);
      if (k < 256 && wrap) wraps++;
      if (k == 66)  chk("per_s64", {16'h0, sin_out}, 32'h7FFF);
      if (k == 130) chk("per_s128", {16'h0, sin_out}, 32'h0000);
      if (k == 194) chk("per_s192", {16'h0, sin_out}, 32'h8001);
    end
    chk("per_wrap_count", wraps, 1);

    // deferred frequency change, then a load on the carry edge itself
    do_reset();
    enable = 1'b0;
    step(1'b1, 24'h400000, 1'b0);
    enable = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b1, 24'h800000, 1'b0);
    chk("defer_lp_set", {31'h0, load_pending}, 32'h1);
    step(1'b0, '0, 1'b0);
    chk("defer_lp_hold", {31'h0, load_pending}, 32'h1);
    step(1'b0, '0, 1'b0);
    chk("defer_lp_clear", {31'h0, load_pending}, 32'h0);
    chk("defer_wrap", {31'h0, wrap}, 32'h1);
    for (int k = 4; k < 10; k++) begin
      step(1'b0, '0, 1'b0);
      if (k >= 6) chk("defer_half_rate", {16'h0, sin_out}, 32'h0000);
    end
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (model_carry_next()) begin
        step(1'b1, 24'h400000, 1'b0);
        chk("carry_load_lp", {31'h0, load_pending}, 32'h0);
        found = 1'b1;
      end else begin
        step(1'b0, '0, 1'b0);
      end
    end
    chk("carry_edge_found", {31'h0, found}, 32'h1);

    // enable gap mid-stream
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0);
      if (k == 1) chk("gap_valid_k1", {31'h0, sin_valid}, 32'h1);
      if (k == 2) chk("gap_valid_k2", {31'h0, sin_valid}, 32'h0);
    end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b0);

    // reset with a pending load discards it
    do_reset();
    enable = 1'b0;
    step(1'b1, 24'h400000, 1'b0);
    enable = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 24'h800000, 1'b0);
    chk("pend_before_rst", {31'h0, load_pending}, 32'h1);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 1'b0);
      if (k == 2) chk("post_rst_valid", {31'h0, sin_valid}, 32'h1);
      if (k == 2) chk("post_rst_first", {16'h0, sin_out}, 32'h0000);
    end

    // randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [23:0] fw;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) phase_off = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       fw = 24'($urandom);
        1:       fw = 24'($urandom_range(0, 24'h0FFFFF));
        default: fw = {8'($urandom_range(1, 255)), 16'h0000};
      endcase
      step(($urandom_range(0, 11) == 0), fw, ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
